parking_meter_countdown: RTL and testbench
==========================================

# parking_meter_countdown

- Consumer of the one-second timer output; sits directly downstream of it.
- Holds the remaining parking time in seconds and decrements it once per second.
- Accepts coin/add-time and load requests.
- Drives BCD digits and low-time/expired/blink indicators for the display stage.

## Interface
Parameters:
- MAX_SECONDS, 9999 — saturation ceiling for remaining time (must fit 14 bits).
- LOW_THRESHOLD, 200 — remaining below this value (and nonzero) is "low time".

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, single domain.
- second_tick  in  1  one-second timer output, level signal; each rising edge is one second.
- add_valid  in  1  one-cycle pulse: add time per add_sel.
- add_sel  in  2  00 → +60, 01 → +120, 10 → +180, 11 → +300 seconds.
- load_valid  in  1  one-cycle pulse: overwrite remaining with load_value.
- load_value  in  14  value to load; clamped to MAX_SECONDS.
- remaining  out  14  current remaining seconds, binary.
- bcd  out  16  remaining as four BCD digits; [15:12] thousands … [3:0] units.
- low_time  out  1  high in LOW state.
- expired  out  1  high in EXPIRED state.
- blink  out  1  display flash enable.

## Operation
- Tick detection:
  - second_tick passes two synchronizer flops, then a history flop.
  - tick = sync2 & ~hist, a single-cycle pulse per rising edge.
  - All three flops reset to 0. An input already high at reset release therefore yields exactly one tick; this is accepted behaviour.
- Next-value rule, evaluated in the same cycle:
  - load_valid wins outright: remaining ← min(load_value, MAX_SECONDS). Tick and add are dropped that cycle.
  - Otherwise: t = remaining − (tick && remaining ≠ 0).
  - Then remaining ← min(t + add_amount·add_valid, MAX_SECONDS). Compute in 15 bits before clamping.
  - Tick at remaining = 0 has no effect; no underflow.
- State machine, derived from the next value of remaining:
  - EXPIRED: remaining = 0.
  - LOW: 0 < remaining < LOW_THRESHOLD.
  - RUN: otherwise.
  - Any state may move to any other in one cycle, e.g. an add of 300 from EXPIRED goes straight to RUN.
- blink:
  - RUN: blink = 0.
  - LOW: blink toggles on every accepted tick, giving a 2 s period.
  - EXPIRED: blink toggles on every tick, including ticks that do not decrement.
  - On entry to LOW or EXPIRED, blink is set to 1.
- BCD: remaining is converted to four digits by a combinational double-dabble, then registered.

## Timing
- Reset values: remaining 0, bcd 0x0000, state EXPIRED, expired 1, low_time 0, blink 1, sync/hist flops 0.
- Tick latency: the first clk edge sampling second_tick high is edge E. remaining updates at edge E+2; bcd updates at E+3.
- add/load latency: remaining updates on the edge that samples the pulse; bcd follows one edge later.
- State outputs (low_time, expired, blink) update on the same edge as remaining.
- A second_tick pulse shorter than one clk period may be missed. The upstream timer guarantees ≥1 clk high and ≥1 clk low.
- Reset asserted mid-count: everything returns to reset values on that edge. A pending synchronized tick is discarded.

## Structure
- Shared package, meter_pkg, holds:
  - state encoding: EXPIRED = 2'd0, LOW = 2'd1, RUN = 2'd2;
  - add-amount constants ADD_60, ADD_120, ADD_180, ADD_300;
  - width constant SEC_W = 14.
- One sub-module: seconds_to_bcd4 — purely combinational, 14-bit binary to 16-bit BCD via double-dabble; instantiated once.
- Top holds the synchronizer, next-value arithmetic, state register, blink register and BCD output register.

## Test plan
- Reset, then three add pulses with add_sel = 11 → remaining 900, bcd 0x0900, RUN. Five ticks → 895, bcd 0x0895.
- load_value 201, then 2 ticks → remaining 199, low_time rises on the 2nd tick's update edge, blink = 1. Next tick → 198, blink 0.
- load 1, then tick → remaining 0, expired 1. Further ticks leave remaining at 0 and toggle blink each tick.
- load 9990, then add_sel = 11 → remaining saturates at 9999, bcd 0x9999. A load_value of 16383 → 9999.
- Tick, add (01) and remaining 100 all arrive in the same cycle → remaining 219, RUN. Load and add in the same cycle → load value wins.
- second_tick held high across reset release → exactly one decrement. Reset asserted during LOW → remaining 0, expired 1, bcd 0x0000 on the next edge.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared types and constants for the parking meter countdown.
// Holds the state encoding, the add-time amounts and the seconds width.
package meter_pkg;

    localparam int SEC_W = 14;

    typedef enum logic [1:0] {
        EXPIRED = 2'd0,
        LOW     = 2'd1,
        RUN     = 2'd2
    } meter_state_t;

    localparam logic [SEC_W:0] ADD_60  = 15'd60;
    localparam logic [SEC_W:0] ADD_120 = 15'd120;
    localparam logic [SEC_W:0] ADD_180 = 15'd180;
    localparam logic [SEC_W:0] ADD_300 = 15'd300;

    function automatic logic [SEC_W:0] add_amount(input logic [1:0] sel);
        case (sel)
            2'b00:   return ADD_60;
            2'b01:   return ADD_120;
            2'b10:   return ADD_180;
            default: return ADD_300;
        endcase
    endfunction

endpackage

// File: rtl/seconds_to_bcd4.sv
// Combinational 14-bit binary to four-digit BCD converter (double-dabble).
module seconds_to_bcd4
    import meter_pkg::*;
(
    input  logic [SEC_W-1:0] bin,
    output logic [15:0]      bcd
);

    logic [SEC_W+15:0] sr;

    always_comb begin
        sr = {16'd0, bin};
        for (int i = 0; i < SEC_W; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sr[SEC_W + 4*d +: 4] >= 4'd5) begin
                    sr[SEC_W + 4*d +: 4] = sr[SEC_W + 4*d +: 4] + 4'd3;
                end
            end
            sr = sr << 1;
        end
        bcd = sr[SEC_W +: 16];
    end

endmodule

// File: rtl/parking_meter_countdown.sv
// Parking meter countdown: synchronizes the one-second tick, keeps remaining
// time with add/load requests, and drives BCD digits plus status indicators.
//
//   state   | meaning
//   EXPIRED | remaining is zero; blink toggles on every tick
//   LOW     | 0 < remaining < LOW_THRESHOLD; blink toggles on each decrement
//   RUN     | remaining at or above LOW_THRESHOLD; blink off
module parking_meter_countdown
    import meter_pkg::*;
#(
    parameter int MAX_SECONDS   = 9999,
    parameter int LOW_THRESHOLD = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             second_tick,
    input  logic             add_valid,
    input  logic [1:0]       add_sel,
    input  logic             load_valid,
    input  logic [SEC_W-1:0] load_value,
    output logic [SEC_W-1:0] remaining,
    output logic [15:0]      bcd,
    output logic             low_time,
    output logic             expired,
    output logic             blink
);

    localparam logic [SEC_W:0]   MAX_EXT = (SEC_W+1)'(MAX_SECONDS);
    localparam logic [SEC_W-1:0] LOW_LIM = SEC_W'(LOW_THRESHOLD);

    logic             sync1, sync2, hist;
    logic             tick;
    logic             accepted;
    logic [SEC_W:0]   sum;
    logic [SEC_W-1:0] rem_q, rem_d;
    meter_state_t     state_q, state_d;
    logic             blink_q, blink_d;
    logic [15:0]      bcd_q, bcd_comb;

    assign tick = sync2 & ~hist;

    always_comb begin
        accepted = 1'b0;
        sum      = '0;
        rem_d    = rem_q;
        state_d  = state_q;
        blink_d  = blink_q;

        if (load_valid) begin
            sum = {1'b0, load_value};
        end else begin
            accepted = tick && (rem_q != '0);
            sum = {1'b0, rem_q} - {{SEC_W{1'b0}}, accepted}
                + (add_valid ? add_amount(add_sel) : '0);
        end
        rem_d = (sum > MAX_EXT) ? MAX_EXT[SEC_W-1:0] : sum[SEC_W-1:0];

        if (rem_d == '0)          state_d = EXPIRED;
        else if (rem_d < LOW_LIM) state_d = LOW;
        else                      state_d = RUN;

        // Entering LOW/EXPIRED forces blink on so the flash starts visibly.
        if (state_d == RUN)           blink_d = 1'b0;
        else if (state_d != state_q)  blink_d = 1'b1;
        else if (state_d == LOW)      blink_d = blink_q ^ accepted;
        else                          blink_d = blink_q ^ (tick & ~load_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            hist    <= 1'b0;
            rem_q   <= '0;
            state_q <= EXPIRED;
            blink_q <= 1'b1;
            bcd_q   <= '0;
        end else begin
            sync1   <= second_tick;
            sync2   <= sync1;
            hist    <= sync2;
            rem_q   <= rem_d;
            state_q <= state_d;
            blink_q <= blink_d;
            bcd_q   <= bcd_comb;
        end
    end

    seconds_to_bcd4 u_bcd (
        .bin (rem_q),
        .bcd (bcd_comb)
    );

    assign remaining = rem_q;
    assign bcd       = bcd_q;
    assign low_time  = (state_q == LOW);
    assign expired   = (state_q == EXPIRED);
    assign blink     = blink_q;

endmodule

// File: tb/tb_parking_meter_countdown.sv
// Scoreboard bench for parking_meter_countdown: a per-cycle reference model
// pushes expected outputs; a negedge monitor pops and compares them.
module tb_parking_meter_countdown;

    logic        clk = 1'b0;
    logic        reset;
    logic        second_tick;
    logic        add_valid;
    logic [1:0]  add_sel;
    logic        load_valid;
    logic [13:0] load_value;
    logic [13:0] remaining;
    logic [15:0] bcd;
    logic        low_time;
    logic        expired;
    logic        blink;

    always #5 clk = ~clk;

    parking_meter_countdown #(.MAX_SECONDS(9999), .LOW_THRESHOLD(200)) dut (
        .clk         (clk),
        .reset       (reset),
        .second_tick (second_tick),
        .add_valid   (add_valid),
        .add_sel     (add_sel),
        .load_valid  (load_valid),
        .load_value  (load_value),
        .remaining   (remaining),
        .bcd         (bcd),
        .low_time    (low_time),
        .expired     (expired),
        .blink       (blink)
    );

    typedef struct {
        int cyc;
        int rem;
        int bcd;
        bit low;
        bit exp;
        bit blk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: plain integer view of the meter.
    int   m_rem = 0;
    int   m_mode = 0;          // 0 expired, 1 low, 2 run
    bit   m_blink = 1'b1;
    int   m_bcd = 0;
    bit   smp[3] = '{0, 0, 0}; // second_tick as sampled 1, 2, 3 edges ago

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int to_bcd(int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8)
             | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic chk(string name, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                chk("stale_entry", e.cyc, cyc);
            end else begin
                chk("remaining", int'(remaining), e.rem);
                chk("bcd", int'(bcd), e.bcd);
                chk("low_time", int'(low_time), int'(e.low));
                chk("expired", int'(expired), int'(e.exp));
                chk("blink", int'(blink), int'(e.blk));
            end
        end
    end

    task automatic step(bit r, bit st, bit av, int sel, bit lv, int val);
        int  amt, nv, nm;
        bit  tk, acc;
        exp_t e;
        reset       = r;
        second_tick = st;
        add_valid   = av;
        add_sel     = sel[1:0];
        load_valid  = lv;
        load_value  = val[13:0];

        if (r) begin
            m_rem = 0; m_mode = 0; m_blink = 1'b1; m_bcd = 0;
            smp = '{0, 0, 0};
        end else begin
            tk  = smp[1] && !smp[2];
            m_bcd = to_bcd(m_rem);
            acc = 1'b0;
            if (lv) begin
                nv = val[13:0];
            end else begin
                acc = tk && (m_rem != 0);
                amt = (sel[1:0] == 0) ? 60 : (sel[1:0] == 1) ? 120
                    : (sel[1:0] == 2) ? 180 : 300;
                nv = m_rem - int'(acc) + (av ? amt : 0);
            end
            if (nv > 9999) nv = 9999;
            nm = (nv == 0) ? 0 : (nv < 200) ? 1 : 2;
            if (nm == 2)                    m_blink = 1'b0;
            else if (nm != m_mode)          m_blink = 1'b1;
            else if (nm == 1 && acc)        m_blink = !m_blink;
            else if (nm == 0 && tk && !lv)  m_blink = !m_blink;
            m_rem  = nv;
            m_mode = nm;
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = st;
        end
        e.cyc = cyc + 1;
        e.rem = m_rem;
        e.bcd = m_bcd;
        e.low = (m_mode == 1);
        e.exp = (m_mode == 0);
        e.blk = m_blink;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        idle(2);
    endtask

    initial begin
        bit st;
        int lv_sel, val;
        reset = 1'b1; second_tick = 1'b0; add_valid = 1'b0;
        add_sel = 2'b00; load_valid = 1'b0; load_value = '0;
        @(negedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 3; i++) step(0, 0, 1, 3, 0, 0);
        idle(2);
        ticks(5);

        step(0, 0, 0, 0, 1, 201);
        idle(1);
        ticks(2);
        ticks(1);

        step(0, 0, 0, 0, 1, 1);
        ticks(1);
        ticks(3);

        step(0, 0, 0, 0, 1, 9990);
        step(0, 0, 1, 3, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 1, 16383);
        idle(1);

        step(0, 0, 0, 0, 1, 100);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        idle(2);
        step(0, 0, 1, 3, 1, 50);
        idle(2);

        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 500);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        idle(2);

        step(0, 0, 0, 0, 1, 150);
        idle(1);
        step(1, 0, 0, 0, 0, 0);
        idle(2);

        st = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) st = !st;
            lv_sel = $urandom_range(0, 3);
            case (lv_sel)
                0:       val = $urandom_range(0, 5);
                1:       val = $urandom_range(190, 210);
                2:       val = $urandom_range(0, 16383);
                default: val = $urandom_range(9900, 9999);
            endcase
            step(($urandom_range(0, 299) == 0), st,
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                 ($urandom_range(0, 19) == 0), val);
        end
        idle(3);
        chk("queue_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
